// File: rtl/vector_wb_packer_pkg.sv
// rtl/vector_wb_packer_pkg.sv - shared types and helpers for the vector writeback packer
package vector_wb_packer_pkg;

  localparam int VLEN_DEFAULT = 64;

  typedef enum logic [1:0] {
    SEW8    = 2'b00,
    SEW16   = 2'b01,
    SEW32   = 2'b10,
    SEW_BAD = 2'b11
  } vsew_e;

  typedef enum logic [2:0] {
    LMUL1 = 3'b000,
    LMUL2 = 3'b001,
    LMUL4 = 3'b010,
    LMUL8 = 3'b011
  } vlmul_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FILL  = 2'b01,
    WRITE = 2'b10,
    DONE  = 2'b11
  } wb_state_e;

  function automatic int unsigned sew_bytes(input vsew_e sew);
    case (sew)
      SEW8:    return 1;
      SEW16:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic int unsigned lmul_regs(input logic [2:0] vlmul);
    // Reserved encodings (1xx) behave as a single register.
    if (vlmul[2]) return 1;
    return 32'd1 << vlmul[1:0];
  endfunction

endpackage

// File: rtl/vector_wb_packer.sv
// rtl/vector_wb_packer.sv - packs SEW-wide element results into byte-enabled register writes
module vector_wb_packer
  import vector_wb_packer_pkg::*;
#(
  parameter int VLEN  = VLEN_DEFAULT,
  parameter int VLENB = VLEN / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [4:0]            vd_base,
  input  logic [1:0]            vsew,
  input  logic [2:0]            vlmul,
  input  logic [$clog2(VLEN):0] vl,
  input  logic                  vm,
  input  logic [VLEN-1:0]       v0_mask,
  input  logic                  elem_valid,
  input  logic [31:0]           elem_data,
  output logic                  elem_ready,
  output logic [VLENB-1:0]      enable,
  output logic [4:0]            vd_addr,
  output logic [VLEN-1:0]       result,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int VL_W = $clog2(VLEN) + 1;
  localparam int IW   = $clog2(VLEN);

  function automatic logic [VLEN-1:0] bytes_to_bits(input logic [VLENB-1:0] be);
    logic [VLEN-1:0] bits;
    for (int i = 0; i < VLENB; i++) bits[i*8 +: 8] = {8{be[i]}};
    return bits;
  endfunction

  wb_state_e        state_q, state_d;
  vsew_e            sew_q, sew_d;
  logic             vm_q, vm_d;
  logic [4:0]       vd_base_q, vd_base_d;
  logic [VL_W-1:0]  vl_eff_q, vl_eff_d;
  logic [VL_W-1:0]  elem_idx_q, elem_idx_d;
  logic [VL_W-1:0]  slot_q, slot_d;
  logic [3:0]       reg_cnt_q, reg_cnt_d;
  logic [VLEN-1:0]  buf_q, buf_d;
  logic [VLENB-1:0] be_q, be_d;
  logic             elem_ready_q, elem_ready_d;
  logic [VLENB-1:0] enable_q, enable_d;
  logic [4:0]       vd_addr_q, vd_addr_d;
  logic [VLEN-1:0]  result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  vsew_e            start_sew;
  int unsigned      start_vlmax;
  logic [VL_W-1:0]  start_vl_eff;

  always_comb begin
    start_sew    = vsew_e'(vsew);
    start_vlmax  = (VLENB / sew_bytes(start_sew)) * lmul_regs(vlmul);
    start_vl_eff = (32'(vl) < start_vlmax) ? vl : VL_W'(start_vlmax);
  end

  int unsigned      nbytes;
  int unsigned      epr;
  int unsigned      shift;
  logic [VLEN-1:0]  elem_bits;
  logic [VLENB-1:0] elem_be;
  logic             elem_active;
  logic             accept;
  logic             reg_full;
  logic             last_elem;

  always_comb begin
    nbytes = sew_bytes(sew_q);
    epr    = VLENB / nbytes;
    shift  = 32'(slot_q) * nbytes;
    case (sew_q)
      SEW8:    elem_bits = VLEN'(elem_data[7:0]);
      SEW16:   elem_bits = VLEN'(elem_data[15:0]);
      default: elem_bits = VLEN'(elem_data);
    endcase
    elem_bits   = elem_bits << (shift * 8);
    elem_be     = VLENB'((32'd1 << nbytes) - 32'd1) << shift;
    elem_active = vm_q | v0_mask[elem_idx_q[IW-1:0]];
    accept      = (state_q == FILL) && elem_ready_q && elem_valid;
    reg_full    = (32'(slot_q) == epr - 32'd1);
    last_elem   = (elem_idx_q == vl_eff_q - VL_W'(1));
  end

  always_comb begin
    state_d      = state_q;
    sew_d        = sew_q;
    vm_d         = vm_q;
    vd_base_d    = vd_base_q;
    vl_eff_d     = vl_eff_q;
    elem_idx_d   = elem_idx_q;
    slot_d       = slot_q;
    reg_cnt_d    = reg_cnt_q;
    buf_d        = buf_q;
    be_d         = be_q;
    elem_ready_d = elem_ready_q;
    vd_addr_d    = vd_addr_q;
    busy_d       = busy_q;
    enable_d     = '0;
    result_d     = '0;
    done_d       = 1'b0;
    error_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (start_sew == SEW_BAD) begin
            error_d = 1'b1;
          end else begin
            sew_d      = start_sew;
            vm_d       = vm;
            vd_base_d  = vd_base;
            vl_eff_d   = start_vl_eff;
            elem_idx_d = '0;
            slot_d     = '0;
            reg_cnt_d  = '0;
            buf_d      = '0;
            be_d       = '0;
            busy_d     = 1'b1;
            if (start_vl_eff == '0) begin
              state_d = DONE;
            end else begin
              state_d      = FILL;
              elem_ready_d = 1'b1;
            end
          end
        end
      end

      FILL: begin
        if (accept) begin
          buf_d      = buf_q | elem_bits;
          be_d       = be_q | (elem_active ? elem_be : '0);
          elem_idx_d = elem_idx_q + VL_W'(1);
          slot_d     = slot_q + VL_W'(1);
          if (reg_full || last_elem) begin
            state_d      = WRITE;
            elem_ready_d = 1'b0;
            enable_d     = be_d;
            result_d     = buf_d & bytes_to_bits(be_d);
            vd_addr_d    = vd_base_q + 5'(reg_cnt_q);
          end
        end
      end

      WRITE: begin
        buf_d     = '0;
        be_d      = '0;
        slot_d    = '0;
        reg_cnt_d = reg_cnt_q + 4'd1;
        if (elem_idx_q == vl_eff_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d      = FILL;
          elem_ready_d = 1'b1;
        end
      end

      DONE: begin
        // Zero-length instructions arrive here without the pulse and raise it one cycle later.
        if (done_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          done_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      sew_q        <= SEW8;
      vm_q         <= 1'b0;
      vd_base_q    <= '0;
      vl_eff_q     <= '0;
      elem_idx_q   <= '0;
      slot_q       <= '0;
      reg_cnt_q    <= '0;
      buf_q        <= '0;
      be_q         <= '0;
      elem_ready_q <= 1'b0;
      enable_q     <= '0;
      vd_addr_q    <= '0;
      result_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sew_q        <= sew_d;
      vm_q         <= vm_d;
      vd_base_q    <= vd_base_d;
      vl_eff_q     <= vl_eff_d;
      elem_idx_q   <= elem_idx_d;
      slot_q       <= slot_d;
      reg_cnt_q    <= reg_cnt_d;
      buf_q        <= buf_d;
      be_q         <= be_d;
      elem_ready_q <= elem_ready_d;
      enable_q     <= enable_d;
      vd_addr_q    <= vd_addr_d;
      result_q     <= result_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign elem_ready = elem_ready_q;
  assign enable     = enable_q;
  assign vd_addr    = vd_addr_q;
  assign result     = result_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule
